// File: rtl/pool_window_gen_if.sv
// Handshake bundle between the pixel source, pool_window_gen and the 2x2 pooling stage.
// Optional frame_done wire appears only when POOL_WIN_FRAME_DONE_EN is defined.
interface pool_window_gen_if #(
    parameter int DW = 8
);
    // pixel stream (upstream side)
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          pix_ready;
    // window stream (pooling-stage side)
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [DW-1:0] data3;
    logic          data_valid;
    logic          data_ready;
`ifdef POOL_WIN_FRAME_DONE_EN
    logic          frame_done;

    // master: the environment feeding pixels and consuming windows
    modport master (
        output pix_in, pix_valid, data_ready,
        input  pix_ready, data0, data1, data2, data3, data_valid, frame_done
    );
    // slave: the window generator itself
    modport slave (
        input  pix_in, pix_valid, data_ready,
        output pix_ready, data0, data1, data2, data3, data_valid, frame_done
    );
`else
    // master: the environment feeding pixels and consuming windows
    modport master (
        output pix_in, pix_valid, data_ready,
        input  pix_ready, data0, data1, data2, data3, data_valid
    );
    // slave: the window generator itself
    modport slave (
        input  pix_in, pix_valid, data_ready,
        output pix_ready, data0, data1, data2, data3, data_valid
    );
`endif
endinterface

// File: rtl/pool_window_gen.sv
// Streaming 2x2 stride-2 window generator feeding the max-pooling stage.
// Even rows fill a one-row line buffer; odd rows pair each column with the
// buffered row and emit one window per two pixels through a held output register.
// Optional build macro: POOL_WIN_FRAME_DONE_EN adds a one-cycle frame_done pulse
// after the last window of each frame is taken downstream.
module pool_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rstn,
    pool_window_gen_if.slave bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_phase_e;

    row_phase_e r_state;
    row_phase_e w_state_nxt;

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic [CW-1:0]            w_col_nxt;
    logic [RW-1:0]            w_row_nxt;
    logic [IMG_W-1:0][DW-1:0] r_linebuf;
    logic [DW-1:0]            r_hold;
    logic [DW-1:0]            r_data0;
    logic [DW-1:0]            r_data1;
    logic [DW-1:0]            r_data2;
    logic [DW-1:0]            r_data3;
    logic                     r_data_valid;

    logic                     w_pix_ready;
    logic                     w_accept;
    logic                     w_xfer;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_lb_we;
    logic                     w_hold_we;
    logic                     w_load;
    logic [CW-1:0]            w_col_lo;

    // Only a window-completing pixel can stall: it would overwrite a held window.
    assign w_pix_ready = !((r_state == ROW_ODD) && r_col[0] && r_data_valid && !bus.data_ready);
    assign w_accept    = bus.pix_valid && w_pix_ready;
    assign w_xfer      = r_data_valid && bus.data_ready;
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_row == ROW_LAST);

    // Even column of the current pair (top-left / bottom-left column).
    always_comb begin
        w_col_lo    = r_col;
        w_col_lo[0] = 1'b0;
    end

    // Next-state and per-pixel write strobes for the row-phase FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_lb_we     = 1'b0;
        w_hold_we   = 1'b0;
        w_load      = 1'b0;
        if (w_accept) begin
            if (w_col_last) begin
                w_col_nxt   = '0;
                w_row_nxt   = w_row_last ? '0 : r_row + 1'b1;
                w_state_nxt = w_row_nxt[0] ? ROW_ODD : ROW_EVEN;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
            case (r_state)
                ROW_EVEN: w_lb_we = 1'b1;
                ROW_ODD: begin
                    if (r_col[0]) w_load    = 1'b1;
                    else          w_hold_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Row phase and raster counters advance only on accepted pixels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ROW_EVEN;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Line buffer holds the even row; entries are overwritten before being read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_linebuf <= '0;
        end else begin
            for (int i = 0; i < IMG_W; i++) begin
                if (w_lb_we && (r_col == CW'(i))) r_linebuf[i] <= bus.pix_in;
            end
        end
    end

    // Bottom-left pixel of the pair waits here for its right neighbour.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          r_hold <= '0;
        else if (w_hold_we) r_hold <= bus.pix_in;
    end

    // Output window register: load on completion, hold under back-pressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data0      <= '0;
            r_data1      <= '0;
            r_data2      <= '0;
            r_data3      <= '0;
            r_data_valid <= 1'b0;
        end else if (w_load) begin
            r_data0      <= r_linebuf[w_col_lo];
            r_data1      <= r_linebuf[r_col];
            r_data2      <= r_hold;
            r_data3      <= bus.pix_in;
            r_data_valid <= 1'b1;
        end else if (w_xfer) begin
            r_data_valid <= 1'b0;
        end
    end

`ifdef POOL_WIN_FRAME_DONE_EN
    logic r_last_win;
    logic r_frame_done;

    // Tag the loaded window as the frame's last one; pulse once it is taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_win   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && r_last_win;
            if (w_load) r_last_win <= w_row_last && w_col_last;
        end
    end

    assign bus.frame_done = r_frame_done;
`endif

    assign bus.pix_ready  = w_pix_ready;
    assign bus.data0      = r_data0;
    assign bus.data1      = r_data1;
    assign bus.data2      = r_data2;
    assign bus.data3      = r_data3;
    assign bus.data_valid = r_data_valid;
endmodule

// File: doc/pool_window_gen.md
# pool_window_gen

Streaming 2x2 window generator placed directly upstream of the 2x2 max-pooling stage. It accepts a raster-order pixel stream and buffers one row internally. For each non-overlapping 2x2 window (stride 2) it presents four pixels on data0..data3 with a valid/ready handshake, which is the exact input format of the pooling stage. It supports back-pressure from the pooling stage, which takes several cycles per window.

## Interface
- IMG_W, 8, feature-map width in pixels; even, >= 2
- IMG_H, 8, feature-map height in rows; even, >= 2
- DW, 8, pixel width in bits; fixed at 8 for compatibility with the pooling stage
- clk  in  1  clock, rising edge
- rstn  in  1  reset: asynchronous, active-low
- pix_in  in  DW  input pixel, raster order (row-major, column 0 first)
- pix_valid  in  1  pix_in is valid
- pix_ready  out  1  block can accept pix_in this cycle
- data0  out  DW  window top-left: row 2r, column 2c
- data1  out  DW  window top-right: row 2r, column 2c+1
- data2  out  DW  window bottom-left: row 2r+1, column 2c
- data3  out  DW  window bottom-right: row 2r+1, column 2c+1
- data_valid  out  1  window on data0..3 is valid
- data_ready  in  1  downstream accepts the window
- frame_done  out  1  only when POOL_WIN_FRAME_DONE_EN is defined; see Configuration

## Operation
- A pixel is accepted on a rising edge where pix_valid && pix_ready. A window transfers on an edge where data_valid && data_ready.
- Counters:
  - col counts 0..IMG_W-1 and is $clog2(IMG_W) bits wide.
  - row counts 0..IMG_H-1 and is $clog2(IMG_H) bits wide.
  - Both advance on each accepted pixel. col wraps to 0 and increments row; row wraps to 0 after IMG_H-1 (next frame).
- Row-phase FSM, derived from row[0]:
  - ROW_EVEN: the accepted pixel is written to linebuf[col], a DW x IMG_W register array.
  - ROW_ODD, col even: the accepted pixel is latched into hold_reg.
  - ROW_ODD, col odd: registers data0=linebuf[col-1], data1=linebuf[col], data2=hold_reg, data3=pix_in, and sets data_valid.
- Transitions: ROW_EVEN->ROW_ODD and ROW_ODD->ROW_EVEN both occur on acceptance of the pixel at col=IMG_W-1.
- Output register: data0..3 and data_valid hold stable while data_valid && !data_ready. data_valid clears on transfer unless a new window loads on the same edge.
- Back-pressure: pix_ready = !(row_odd && col_odd && data_valid && !data_ready). Only a pixel that would complete a window is stalled; even-row pixels and odd-row even-column pixels are always accepted.
- linebuf is not cleared between rows. Each entry is rewritten before it is read.
- Values are passed through unmodified. No arithmetic is performed on pixel data.

## Timing
- Reset values: pix_ready=1, data0..3=0, data_valid=0, frame_done=0. col, row, hold_reg and linebuf are all reset to 0.
- Latency: data_valid rises 1 cycle after the edge that accepts the window-completing pixel.
- Throughput:
  - Up to 1 pixel per cycle.
  - One window per 2 pixels in odd rows.
  - A held window stalls only the next window-completing pixel.
- Simultaneous transfer and load: if a window transfers on the same edge that a completing pixel is accepted, the new window loads and data_valid stays 1.
- Reset mid-frame: all state is cleared and partial windows are discarded. The first pixel after reset is treated as row 0, column 0.
- pix_ready depends combinationally on data_ready. There is no combinational path from pix_valid to any output.

## Configuration
- POOL_WIN_FRAME_DONE_EN:
  - Defined: adds output frame_done (1 bit). It is a single-cycle pulse on the cycle after the final window of a frame (row IMG_H-1, col IMG_W-1) transfers downstream. Reset value is 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- IMG_W=4, IMG_H=2; pixels 0..7 streamed with data_ready=1 -> windows (0,1,4,5), then (2,3,6,7). Each data_valid rises 1 cycle after pixels 5 and 7 are accepted.
- Same stream with data_ready held 0 until 10 cycles after pixel 5 -> pix_ready drops when pixel 7 is offered. Window (0,1,4,5) holds stable. Window (2,3,6,7) follows the release.
- Two back-to-back frames with values 0..7, then 100..107 -> second frame yields (100,101,104,105), (102,103,106,107). No cross-frame mixing.
- Gaps: pix_valid toggling 1,0,1,0 -> same windows as the first scenario. Counters advance only on accepted pixels.
- rstn pulsed low after pixel 5 is accepted but before the window transfers -> data_valid=0 immediately. Pixels 0..7 then yield (0,1,4,5), (2,3,6,7).
- With POOL_WIN_FRAME_DONE_EN: frame_done pulses once per frame, the cycle after (2,3,6,7) transfers. It is never asserted otherwise.
